hazard_unit: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core. It consumes the register-address and control fields that the ID/EX and EX/MEM pipeline registers present, and drives the write-enable and flush inputs of the PC and the IF/ID, ID/EX and EX/MEM registers. It inserts bubbles for data hazards and squashes wrong-path instructions on a taken branch. It also keeps a state register and saturating event counters for debug and performance measurement.

---
 rtl/hazard_unit.sv | 117 +++++++++++
 tb/tb_hazard_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Hazard controller: stalls ID on RAW hazards and squashes wrong-path work on a taken branch.
// MIPS_FORWARDING_EN defined: only load-use stalls; undefined: all EX/MEM RAW hazards stall.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_UsesRt,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_dst,
  input  logic             MEM_RegWrite,
  input  logic [4:0]       MEM_dst,
  input  logic             MEM_Branch,
  input  logic             MEM_Zero,
  output logic             PC_Write,
  output logic             PCSrc,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Flush,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic             match_ex;
  logic             take;
  logic             stall;
  logic [1:0]       hz_state_d,  hz_state_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  always_comb begin
    match_ex = EX_RegWrite && (EX_dst != 5'd0) &&
               ((EX_dst == ID_rs) || (ID_UsesRt && (EX_dst == ID_rt)));
  end

`ifdef MIPS_FORWARDING_EN
  // Forwarding covers everything except a load whose data is not ready until MEM ends.
  logic [5:0] unused_mem_fields;
  assign unused_mem_fields = {MEM_RegWrite, MEM_dst};

  always_comb begin
    stall = EX_MemRead && match_ex;
  end
`else
  logic match_mem;
  logic unused_mem_read;
  assign unused_mem_read = EX_MemRead;

  // WB writes in the first half-cycle, so only EX and MEM producers need to hold ID.
  always_comb begin
    match_mem = MEM_RegWrite && (MEM_dst != 5'd0) &&
                ((MEM_dst == ID_rs) || (ID_UsesRt && (MEM_dst == ID_rt)));
    stall     = match_ex || match_mem;
  end
`endif

  always_comb begin
    take = MEM_Branch && MEM_Zero;
  end

  always_comb begin
    PC_Write     = 1'b1;
    PCSrc        = 1'b0;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    if (!rst) begin
      if (take) begin
        PCSrc        = 1'b1;
        IF_ID_Flush  = 1'b1;
        ID_EX_Flush  = 1'b1;
        EX_MEM_Flush = 1'b1;
      end else if (stall) begin
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Flush = 1'b1;
      end
    end
  end

  always_comb begin
    hz_state_d  = ST_RUN;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (rst) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else if (take) begin
      hz_state_d = ST_FLUSH;
      if (flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (stall) begin
      hz_state_d = ST_STALL;
      if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    hz_state_q  <= hz_state_d;
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign hz_state  = hz_state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: vector table, pipeline sequences and random stimulus vs. a rule-level model.
module tb_hazard_unit;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rs = '0, rt = '0, ex_dst = '0, mem_dst = '0;
  logic uses_rt = 1'b0, ex_rw = 1'b0, ex_mr = 1'b0, mem_rw = 1'b0, br = 1'b0, zero = 1'b0;

  logic pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0] hz_state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_rs(rs), .ID_rt(rt), .ID_UsesRt(uses_rt),
    .EX_RegWrite(ex_rw), .EX_MemRead(ex_mr), .EX_dst(ex_dst),
    .MEM_RegWrite(mem_rw), .MEM_dst(mem_dst),
    .MEM_Branch(br), .MEM_Zero(zero),
    .PC_Write(pc_write), .PCSrc(pc_src), .IF_ID_Write(if_id_write),
    .IF_ID_Flush(if_id_flush), .ID_EX_Flush(id_ex_flush), .EX_MEM_Flush(ex_mem_flush),
    .hz_state(hz_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int m_state = 0, m_stall = 0, m_flush = 0;
  int seen_stalls = 0;

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       uses_rt, ex_rw, ex_mr;
    logic [4:0] ex_dst;
    logic       mem_rw;
    logic [4:0] mem_dst;
    logic       br, zero;
    int         cls_fwd, cls_nofwd;  // 0 run, 1 stall, 2 flush
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input string name, input int r_s, input int r_t, input bit ur,
                         input bit erw, input bit emr, input int ed, input bit mrw, input int md,
                         input bit b, input bit z, input int cf, input int cn);
    vec_t v;
    v.name = name; v.rs = 5'(r_s); v.rt = 5'(r_t); v.uses_rt = ur;
    v.ex_rw = erw; v.ex_mr = emr; v.ex_dst = 5'(ed); v.mem_rw = mrw; v.mem_dst = 5'(md);
    v.br = b; v.zero = z; v.cls_fwd = cf; v.cls_nofwd = cn;
    tbl.push_back(v);
  endtask

  task automatic set_in(input int r_s, input int r_t, input bit ur, input bit erw, input bit emr,
                        input int ed, input bit mrw, input int md, input bit b, input bit z);
    rs = 5'(r_s); rt = 5'(r_t); uses_rt = ur; ex_rw = erw; ex_mr = emr; ex_dst = 5'(ed);
    mem_rw = mrw; mem_dst = 5'(md); br = b; zero = z;
  endtask

  // Decision from the hazard rules, evaluated on the currently driven fields.
  function automatic int model_cls();
    bit reads_ex, reads_mem, st;
    reads_ex  = ex_rw  && ex_dst  != 0 && (ex_dst  == rs || (uses_rt && ex_dst  == rt));
    reads_mem = mem_rw && mem_dst != 0 && (mem_dst == rs || (uses_rt && mem_dst == rt));
`ifdef MIPS_FORWARDING_EN
    st = ex_mr && reads_ex;
    if (reads_mem) st = st;
`else
    st = reads_ex || reads_mem;
`endif
    if (br && zero) return 2;
    if (st) return 1;
    return 0;
  endfunction

  // Called just after a falling edge with inputs driven; advances one full cycle.
  task automatic step(input string name, input int exp_cls);
    int c;
    logic [5:0] exp_ctrl;
    #1;
    c = rst ? 0 : ((exp_cls >= 0) ? exp_cls : model_cls());
    exp_ctrl = {c != 1, c == 2, c != 1, c == 2, c != 0, c == 2};
    chk({name, ".ctrl"}, int'({pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush}),
        int'(exp_ctrl));
    if (pc_write == 1'b0) seen_stalls++;
    @(posedge clk);
    if (rst) begin
      m_state = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_state = c;
      if (c == 1 && m_stall < CMAX) m_stall++;
      if (c == 2 && m_flush < CMAX) m_flush++;
    end
    #1;
    chk({name, ".state"}, int'(hz_state), m_state);
    chk({name, ".stall_cnt"}, int'(stall_cnt), m_stall);
    chk({name, ".flush_cnt"}, int'(flush_cnt), m_flush);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset", 0);
    rst = 1'b0;
  endtask

  int base;

  initial begin
    add_vec("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec("ex_alu_rs",   2, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 1);
    add_vec("ex_load_rs",  2, 7, 1, 1, 1, 2, 0, 0, 0, 0, 1, 1);
    add_vec("ex_dst0",     0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add_vec("rt_unused",   1, 3, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0);
    add_vec("rt_used",     1, 3, 1, 1, 1, 3, 0, 0, 0, 0, 1, 1);
    add_vec("mem_rs",      5, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1);
    add_vec("mem_dst0",    0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add_vec("br_not_tkn",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add_vec("br_tkn_load", 2, 0, 0, 1, 1, 2, 0, 0, 1, 1, 2, 2);
    add_vec("zero_no_br",  4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add_vec("memrd_no_rw", 2, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0);
    add_vec("mem_rt_used", 1, 6, 1, 0, 0, 0, 1, 6, 0, 0, 0, 1);

    @(negedge clk);
    // Reset held two cycles with a hazard present: controls must stay in the pass-through pattern.
    rst = 1'b1;
    set_in(2, 0, 0, 1, 1, 2, 1, 2, 0, 0);
    step("rst_hold0", 0);
    step("rst_hold1", 0);
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("post_reset.state", int'(hz_state), 0);
    chk("post_reset.stall_cnt", int'(stall_cnt), 0);
    chk("post_reset.flush_cnt", int'(flush_cnt), 0);
    chk("post_reset.pc_write", int'(pc_write), 1);
    @(negedge clk);

    foreach (tbl[i]) begin
      set_in(tbl[i].rs, tbl[i].rt, tbl[i].uses_rt, tbl[i].ex_rw, tbl[i].ex_mr, tbl[i].ex_dst,
             tbl[i].mem_rw, tbl[i].mem_dst, tbl[i].br, tbl[i].zero);
`ifdef MIPS_FORWARDING_EN
      step(tbl[i].name, tbl[i].cls_fwd);
`else
      step(tbl[i].name, tbl[i].cls_nofwd);
`endif
    end

`ifdef MIPS_FORWARDING_EN
    // lw $2,0($1) in EX with add $3,$2,$4 in ID, then the bubble follows the load.
    do_reset();
    seen_stalls = 0;
    set_in(2, 4, 1, 1, 1, 2, 0, 0, 0, 0);
    step("lu_c0", 1);
    chk("lu.state_after_stall", int'(hz_state), 1);
    set_in(2, 4, 1, 0, 0, 0, 1, 2, 0, 0);
    step("lu_c1", 0);
    set_in(2, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    step("lu_c2", 0);
    chk("lu.stall_cycles", seen_stalls, 1);
    chk("lu.stall_cnt", int'(stall_cnt), 1);
`else
    // add $2,$1,$1 in EX with sub $3,$2,$1 in ID; producer walks EX -> MEM -> WB.
    do_reset();
    seen_stalls = 0;
    set_in(2, 1, 1, 1, 0, 2, 0, 0, 0, 0);
    step("raw_c0", 1);
    set_in(2, 1, 1, 0, 0, 0, 1, 2, 0, 0);
    step("raw_c1", 1);
    set_in(2, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step("raw_c2", 0);
    chk("raw.stall_cycles", seen_stalls, 2);
    chk("raw.stall_cnt", int'(stall_cnt), 2);
    // Same pair writing $0: nothing to wait for.
    do_reset();
    seen_stalls = 0;
    set_in(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    step("raw0_c0", 0);
    set_in(0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    step("raw0_c1", 0);
    chk("raw0.stall_cycles", seen_stalls, 0);
    chk("raw0.stall_cnt", int'(stall_cnt), 0);
`endif

    // Taken branch coinciding with a load-use stall.
    do_reset();
    set_in(2, 0, 0, 1, 1, 2, 0, 0, 1, 1);
    step("tkn_lu", 2);
    chk("tkn.flush_cnt", int'(flush_cnt), 1);
    chk("tkn.stall_cnt", int'(stall_cnt), 0);
    chk("tkn.state", int'(hz_state), 2);

    // Saturation after 20 stall cycles.
    do_reset();
    set_in(3, 0, 0, 1, 1, 3, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) step("sat", 1);
    chk("sat.stall_cnt", int'(stall_cnt), CMAX);
    // Flush counter saturates too.
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 17; k++) step("fsat", 2);
    chk("fsat.flush_cnt", int'(flush_cnt), CMAX);
    chk("fsat.stall_cnt_kept", int'(stall_cnt), CMAX);

    // Reset arriving in the middle of a stall.
    do_reset();
    set_in(3, 0, 0, 1, 1, 3, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step("pre_rst", 1);
    base = int'(stall_cnt);
    chk("pre_rst.stall_cnt", base, 3);
    rst = 1'b1;
    step("mid_rst", 0);
    chk("mid_rst.state", int'(hz_state), 0);
    chk("mid_rst.stall_cnt", int'(stall_cnt), 0);
    chk("mid_rst.pc_write", int'(pc_write), 1);
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("after_rst", 0);

    // Random traffic over a narrow register range to make matches frequent.
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 39) == 0);
      set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
      step("rand", -1);
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
